// File: rtl/irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler
//
// Shares one water tank between the splinker and dripper zones. Zone requests
// are latched into pending bits and granted round-robin, so at most one valve
// is open at any time. Each grant first holds all valves closed for a settle
// gap, then opens the selected zone valve for a fixed watering window. A low
// tank preempts watering and opens the inlet valve. If the tank does not fill
// within a timeout, the block enters a sticky fault state.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   req_splinker    splinker watering request (pulse or level)
//   req_dripper     dripper watering request (pulse or level)
//   tank_low        tank level below minimum
//   tank_full       tank level at maximum
//   splinker_valve  splinker zone valve open
//   dripper_valve   dripper zone valve open
//   fill_valve      tank inlet valve open
//   busy            scheduler is not idle
//   done_splinker   one-cycle pulse on the last cycle of a splinker window
//   done_dripper    one-cycle pulse on the last cycle of a dripper window
//   error           sticky fault flag, cleared only by reset
// -----------------------------------------------------------------------------
module irrigation_scheduler #(
  parameter int WATER_CYCLES = 16,
  parameter int GAP_CYCLES   = 4,
  parameter int FILL_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic req_splinker,
  input  logic req_dripper,
  input  logic tank_low,
  input  logic tank_full,
  output logic splinker_valve,
  output logic dripper_valve,
  output logic fill_valve,
  output logic busy,
  output logic done_splinker,
  output logic done_dripper,
  output logic error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWITCH = 3'd1,
    S_WATER  = 3'd2,
    S_FILL   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  typedef enum logic {
    Z_SPLINKER = 1'b0,
    Z_DRIPPER  = 1'b1
  } zone_t;

  localparam logic [CNT_W-1:0] WATER_LOAD = CNT_W'(WATER_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  zone_t             sel, sel_next;
  zone_t             last_grant, last_grant_next;
  logic              pend_splinker, pend_splinker_next;
  logic              pend_dripper, pend_dripper_next;

  logic              want_splinker, want_dripper;
  zone_t             pick;
  logic              window_end;

  // A pending request or a request arriving this cycle both count as demand.
  assign want_splinker = pend_splinker | req_splinker;
  assign want_dripper  = pend_dripper  | req_dripper;

  // On a tie the zone that was not served last wins.
  always_comb begin
    if (want_splinker && want_dripper) begin
      pick = (last_grant == Z_DRIPPER) ? Z_SPLINKER : Z_DRIPPER;
    end else if (want_splinker) begin
      pick = Z_SPLINKER;
    end else begin
      pick = Z_DRIPPER;
    end
  end

  // A window completes on its last cycle unless a low tank aborts it then.
  assign window_end = (state == S_WATER) && (cnt == CNT_ONE) && !tank_low;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register is cleared asynchronously so the valves close the
  // moment reset falls, without waiting for a clock edge; all sequential
  // updates are non-blocking so each register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sel           <= Z_SPLINKER;
      last_grant    <= Z_DRIPPER;
      pend_splinker <= 1'b0;
      pend_dripper  <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      sel           <= sel_next;
      last_grant    <= last_grant_next;
      pend_splinker <= pend_splinker_next;
      pend_dripper  <= pend_dripper_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    sel_next        = sel;
    last_grant_next = last_grant;

    // A new request always sets the pending bit, even in the cycle that
    // completes the same zone.
    pend_splinker_next = req_splinker |
                         (pend_splinker & ~(window_end && sel == Z_SPLINKER));
    pend_dripper_next  = req_dripper |
                         (pend_dripper & ~(window_end && sel == Z_DRIPPER));

    unique case (state)
      S_IDLE: begin
        if (tank_low && tank_full) begin
          state_next = S_FAULT;
        end else if (tank_low) begin
          state_next = S_FILL;
          cnt_next   = FILL_LOAD;
        end else if (want_splinker || want_dripper) begin
          state_next = S_SWITCH;
          cnt_next   = GAP_LOAD;
          sel_next   = pick;
        end
      end

      S_SWITCH: begin
        if (cnt == CNT_ONE) begin
          state_next = S_WATER;
          cnt_next   = WATER_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end

      S_WATER: begin
        if (tank_low) begin
          // Abort: the pending bit stays set, so the whole window reruns.
          state_next = S_FILL;
          cnt_next   = FILL_LOAD;
        end else if (cnt == CNT_ONE) begin
          state_next      = S_IDLE;
          cnt_next        = '0;
          last_grant_next = sel;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end

      S_FILL: begin
        // Contradictory sensors beat a full tank, which beats the timeout.
        if (tank_low && tank_full) begin
          state_next = S_FAULT;
        end else if (tank_full) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_ONE) begin
          state_next = S_FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end

      S_FAULT: begin
        state_next = S_FAULT;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: valves come from registered state and sel only.
  // ---------------------------------------------------------------------------
  always_comb begin
    splinker_valve = (state == S_WATER) && (sel == Z_SPLINKER);
    dripper_valve  = (state == S_WATER) && (sel == Z_DRIPPER);
    fill_valve     = (state == S_FILL);
    busy           = (state != S_IDLE);
    error          = (state == S_FAULT);
    done_splinker  = window_end && (sel == Z_SPLINKER);
    done_dripper   = window_end && (sel == Z_DRIPPER);
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// tb_irrigation_scheduler
//
// Directed bench for irrigation_scheduler. A behavioural model tracks the
// current activity (idle / settle gap / watering / filling / fault) with an
// elapsed-cycle count and is compared against the DUT on every falling edge.
// Directed scenarios add hand-computed expectations on durations, latencies
// and pulse counts.
// -----------------------------------------------------------------------------
module tb_irrigation_scheduler;

  localparam int WATER = 16;
  localparam int GAP   = 4;
  localparam int FILLT = 64;
  localparam int CW    = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_splinker = 1'b0;
  logic req_dripper  = 1'b0;
  logic tank_low     = 1'b0;
  logic tank_full    = 1'b0;
  logic splinker_valve, dripper_valve, fill_valve, busy;
  logic done_splinker, done_dripper, error;

  irrigation_scheduler #(
    .WATER_CYCLES(WATER),
    .GAP_CYCLES  (GAP),
    .FILL_TIMEOUT(FILLT),
    .CNT_W       (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_splinker  (req_splinker),
    .req_dripper   (req_dripper),
    .tank_low      (tank_low),
    .tank_full     (tank_full),
    .splinker_valve(splinker_valve),
    .dripper_valve (dripper_valve),
    .fill_valve    (fill_valve),
    .busy          (busy),
    .done_splinker (done_splinker),
    .done_dripper  (done_dripper),
    .error         (error)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_GAP, M_WATER, M_FILL, M_FAULT} mode_t;

  mode_t m_mode    = M_IDLE;
  int    m_elapsed = 0;    // cycles already spent in the current activity
  int    m_zone    = 0;    // 0 = splinker, 1 = dripper
  int    m_last    = 1;    // zone served last; dripper so splinker wins first
  bit    m_pend [2] = '{1'b0, 1'b0};

  function automatic bit m_ends(input int z);
    return (m_mode == M_WATER) && (m_zone == z) &&
           (m_elapsed == WATER - 1) && !tank_low;
  endfunction

  task automatic model_step();
    bit fin  [2];
    bit want [2];
    if (!reset) begin
      m_mode    = M_IDLE;
      m_elapsed = 0;
      m_zone    = 0;
      m_last    = 1;
      m_pend    = '{1'b0, 1'b0};
    end else begin
      fin[0]  = m_ends(0);
      fin[1]  = m_ends(1);
      want[0] = m_pend[0] | req_splinker;
      want[1] = m_pend[1] | req_dripper;
      case (m_mode)
        M_IDLE: begin
          if (tank_low && tank_full) m_mode = M_FAULT;
          else if (tank_low) begin
            m_mode = M_FILL; m_elapsed = 0;
          end else if (want[0] || want[1]) begin
            m_mode    = M_GAP;
            m_elapsed = 0;
            if (want[0] && want[1]) m_zone = 1 - m_last;
            else                    m_zone = want[0] ? 0 : 1;
          end
        end
        M_GAP: begin
          if (m_elapsed + 1 == GAP) begin
            m_mode = M_WATER; m_elapsed = 0;
          end else m_elapsed++;
        end
        M_WATER: begin
          if (tank_low) begin
            m_mode = M_FILL; m_elapsed = 0;
          end else if (m_elapsed + 1 == WATER) begin
            m_mode = M_IDLE; m_last = m_zone;
          end else m_elapsed++;
        end
        M_FILL: begin
          if (tank_low && tank_full)      m_mode = M_FAULT;
          else if (tank_full)             m_mode = M_IDLE;
          else if (m_elapsed + 1 == FILLT) m_mode = M_FAULT;
          else                            m_elapsed++;
        end
        default: ;
      endcase
      m_pend[0] = req_splinker | (m_pend[0] & !fin[0]);
      m_pend[1] = req_dripper  | (m_pend[1] & !fin[1]);
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  // ---------------------------------------------------------------------------
  // Compare process and activity monitor
  // ---------------------------------------------------------------------------
  int c_checks = 0;
  int c_fails  = 0;
  int cyc      = 0;
  int n_sv = 0, n_dv = 0, n_fv = 0, n_ds = 0, n_dd = 0;
  int last_sv_cyc = -1;
  int dv_rise_cyc = -1;
  logic prev_dv = 1'b0;

  task automatic cmp(input string name, input logic act, input logic exp);
    c_checks++;
    if (act !== exp) begin
      c_fails++;
      $display("FAIL cmp_%s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    cyc++;
    cmp("splinker_valve", splinker_valve, m_mode == M_WATER && m_zone == 0);
    cmp("dripper_valve",  dripper_valve,  m_mode == M_WATER && m_zone == 1);
    cmp("fill_valve",     fill_valve,     m_mode == M_FILL);
    cmp("busy",           busy,           m_mode != M_IDLE);
    cmp("error",          error,          m_mode == M_FAULT);
    cmp("done_splinker",  done_splinker,  m_ends(0));
    cmp("done_dripper",   done_dripper,   m_ends(1));
    cmp("one_valve", (int'(splinker_valve) + int'(dripper_valve) + int'(fill_valve)) <= 1, 1'b1);
    n_sv += int'(splinker_valve);
    n_dv += int'(dripper_valve);
    n_fv += int'(fill_valve);
    n_ds += int'(done_splinker);
    n_dd += int'(done_dripper);
    if (splinker_valve) last_sv_cyc = cyc;
    if (dripper_valve && !prev_dv) dv_rise_cyc = cyc;
    prev_dv = dripper_valve;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    req_splinker = 1'b0;
    req_dripper  = 1'b0;
    tank_low     = 1'b0;
    tank_full    = 1'b0;
    reset        = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wait_valve(input string name, input int z, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if ((z == 0) ? splinker_valve : dripper_valve) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  initial begin
    int s_sv, s_dv, s_fv, s_ds, s_dd;

    // Reset state
    #1 reset = 1'b0;
    tick(2);
    check("reset_outputs",
          {splinker_valve, dripper_valve, fill_valve, busy,
           done_splinker, done_dripper, error}, 0);
    reset = 1'b1;
    tick(1);

    // 1: single splinker request
    s_sv = n_sv; s_ds = n_ds;
    req_splinker = 1'b1;
    tick(1);
    req_splinker = 1'b0;
    check("t1_busy_next_cycle", busy, 1);
    tick(GAP - 1);
    check("t1_valve_closed_in_gap", splinker_valve, 0);
    tick(1);
    check("t1_valve_rise_after_gap", splinker_valve, 1);
    tick(25);
    check("t1_valve_cycles", n_sv - s_sv, 16);
    check("t1_done_pulses", n_ds - s_ds, 1);
    check("t1_idle_again", busy, 0);

    // 2: simultaneous requests, splinker first then dripper
    do_reset();
    s_sv = n_sv; s_dv = n_dv; s_ds = n_ds; s_dd = n_dd;
    req_splinker = 1'b1;
    req_dripper  = 1'b1;
    tick(1);
    req_splinker = 1'b0;
    req_dripper  = 1'b0;
    tick(50);
    check("t2_splinker_cycles", n_sv - s_sv, 16);
    check("t2_dripper_cycles", n_dv - s_dv, 16);
    check("t2_done_splinker", n_ds - s_ds, 1);
    check("t2_done_dripper", n_dd - s_dd, 1);
    // one idle cycle plus the settle gap between the two windows
    check("t2_dripper_follows", dv_rise_cyc - last_sv_cyc, GAP + 2);

    // 3: low tank aborts a dripper window, which reruns after filling
    do_reset();
    s_dv = n_dv; s_dd = n_dd; s_fv = n_fv;
    req_dripper = 1'b1;
    tick(1);
    req_dripper = 1'b0;
    wait_valve("t3_wait_dripper", 1, 20);
    tick(7);
    tank_low = 1'b1;
    tick(1);
    tank_low = 1'b0;
    check("t3_valve_dropped", dripper_valve, 0);
    check("t3_fill_open", fill_valve, 1);
    tick(9);
    tank_full = 1'b1;
    tick(1);
    tank_full = 1'b0;
    check("t3_idle_after_fill", busy, 0);
    tick(30);
    check("t3_dripper_cycles", n_dv - s_dv, 8 + 16);
    check("t3_done_dripper", n_dd - s_dd, 1);
    check("t3_fill_cycles", n_fv - s_fv, 10);

    // 4: fill timeout
    do_reset();
    s_fv = n_fv;
    tank_low = 1'b1;
    tick(80);
    check("t4_fill_cycles", n_fv - s_fv, 64);
    check("t4_error", error, 1);
    check("t4_valves_closed", {splinker_valve, dripper_valve, fill_valve}, 0);
    check("t4_busy", busy, 1);
    s_sv = n_sv;
    req_splinker = 1'b1;
    tick(1);
    req_splinker = 1'b0;
    tick(30);
    check("t4_request_ignored", n_sv - s_sv, 0);
    check("t4_error_sticky", error, 1);
    tank_low = 1'b0;

    // 5: contradictory sensors in idle
    do_reset();
    tank_low  = 1'b1;
    tank_full = 1'b1;
    tick(1);
    check("t5_fault_next_edge", error, 1);
    tank_low  = 1'b0;
    tank_full = 1'b0;
    tick(3);
    check("t5_fault_sticky", error, 1);

    // 6: asynchronous reset mid-window
    do_reset();
    req_splinker = 1'b1;
    tick(1);
    req_splinker = 1'b0;
    wait_valve("t6_wait_splinker", 0, 20);
    tick(5);
    #2 reset = 1'b0;
    #1;
    check("t6_valve_closed_async", splinker_valve, 0);
    check("t6_busy_cleared_async", busy, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    s_sv = n_sv;
    tick(40);
    check("t6_no_rerun", n_sv - s_sv, 0);
    check("t6_idle", busy, 0);

    $display("%0d/%0d checks passed",
             (n_checks + c_checks) - (n_fails + c_fails), n_checks + c_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
